// File: rtl/mvu_ctrl_seq.sv
// mvu_ctrl_seq: job sequencer driving one MVU's bank addresses, shacc/quantizer controls and writeback.
// Define MVU_CTRL_PERF_EN to add the perf_cycles/perf_stalls counters.
module mvu_ctrl_seq #(
  parameter int BWBANKA   = 9,
  parameter int BDBANKA   = 14,
  parameter int QMSBLOCBD = 5,
  parameter int RDLAT     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BWBANKA-1:0]   cfg_wbase,
  input  logic [BDBANKA-1:0]   cfg_dbase,
  input  logic [BDBANKA-1:0]   cfg_obase,
  input  logic [3:0]           cfg_iprec,
  input  logic [3:0]           cfg_wprec,
  input  logic [3:0]           cfg_oprec,
  input  logic [7:0]           cfg_ncol,
  input  logic [7:0]           cfg_nrow,
  input  logic [QMSBLOCBD-1:0] cfg_qmsb,
  output logic                 busy,
  output logic                 done,
  output logic [BWBANKA-1:0]   rdw_addr,
  output logic                 rdd_en,
  input  logic                 rdd_grnt,
  output logic [BDBANKA-1:0]   rdd_addr,
  output logic                 shacc_clr,
  output logic                 shacc_load,
  output logic                 shacc_acc,
  output logic                 shacc_sh,
  output logic                 quant_clr,
  output logic                 quant_load,
  output logic                 quant_step,
  output logic [QMSBLOCBD-1:0] quant_msbidx,
  output logic                 wrd_en,
  input  logic                 wrd_grnt,
  output logic [BDBANKA-1:0]   wrd_addr
`ifdef MVU_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls
`endif
);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, QLOAD, QOUT, DONE} state_t;
  state_t state_q, state_d;

  logic [BWBANKA-1:0]   wbase_q;
  logic [BDBANKA-1:0]   dbase_q, obase_q;
  logic [3:0]           iprec_q, wprec_q, oprec_q, k_q;
  logic [7:0]           ncol_q, nrow_q, r_q, col_q, dcnt_q;
  logic [QMSBLOCBD-1:0] qmsb_q;
  logic [4:0]           s_q, wb_q;
  logic                 row_entry_q, beat0_q;
  logic [RDLAT:1]       vld_pipe;
  logic [RDLAT:1][1:0]  flg_pipe;

  logic       degen, issue, new_s, col_last, wb_last, beat_last;
  logic       wr_fire, k_last, row_last, drain_end, acc_enter;
  logic [3:0] src_wp, src_ip;
  logic [4:0] wp1, ip1, s_m1, wb_hi, wb_hi_m1, wb_lo, s_init, wb_init;
  logic [31:0] w_off, d_off, o_off;

  assign degen = (cfg_iprec == 0) | (cfg_wprec == 0) | (cfg_oprec == 0) |
                 (cfg_ncol == 0) | (cfg_nrow == 0);

  // Significance/weight-bit bounds: wb walks min(s,wp-1) down to max(0,s-ip+1)
  assign wp1       = {1'b0, wprec_q} - 5'd1;
  assign ip1       = {1'b0, iprec_q} - 5'd1;
  assign s_m1      = s_q - 5'd1;
  assign wb_hi     = (s_q < wp1) ? s_q : wp1;
  assign wb_hi_m1  = (s_m1 < wp1) ? s_m1 : wp1;
  assign wb_lo     = (s_q >= ip1) ? s_q - ip1 : 5'd0;
  assign src_wp    = (state_q == IDLE) ? cfg_wprec : wprec_q;
  assign src_ip    = (state_q == IDLE) ? cfg_iprec : iprec_q;
  assign s_init    = {1'b0, src_wp} + {1'b0, src_ip} - 5'd2;
  assign wb_init   = {1'b0, src_wp} - 5'd1;

  assign issue     = (state_q == ACC) & rdd_grnt;
  assign col_last  = col_q == ncol_q - 8'd1;
  assign wb_last   = wb_q == wb_lo;
  assign beat_last = col_last & wb_last & (s_q == 5'd0);
  assign new_s     = (col_q == 8'd0) & (wb_q == wb_hi);
  assign wr_fire   = (state_q == QOUT) & wrd_grnt;
  assign k_last    = k_q == oprec_q - 4'd1;
  assign row_last  = r_q == nrow_q - 8'd1;
  assign drain_end = dcnt_q == 8'(RDLAT - 1);
  assign acc_enter = (state_d == ACC) & (state_q != ACC);

  assign w_off = (32'(r_q) * 32'(ncol_q) + 32'(col_q)) * 32'(wprec_q) + 32'(wb_q);
  assign d_off = 32'(col_q) * 32'(iprec_q) + 32'(s_q - wb_q);
  assign o_off = 32'(r_q) * 32'(oprec_q) + 32'(k_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = state_q != IDLE;
    done         = 1'b0;
    rdw_addr     = '0;
    rdd_en       = 1'b0;
    rdd_addr     = '0;
    shacc_clr    = 1'b0;
    quant_clr    = 1'b0;
    quant_load   = 1'b0;
    quant_step   = 1'b0;
    quant_msbidx = (state_q != IDLE) ? qmsb_q : '0;
    wrd_en       = 1'b0;
    wrd_addr     = '0;
    // Delayed beats line up with operand arrival at the accumulator
    shacc_load   = vld_pipe[RDLAT] & flg_pipe[RDLAT][1];
    shacc_acc    = vld_pipe[RDLAT] & ~flg_pipe[RDLAT][1];
    shacc_sh     = vld_pipe[RDLAT] & flg_pipe[RDLAT][0] & ~flg_pipe[RDLAT][1];
    unique case (state_q)
      IDLE:  if (start) state_d = degen ? DONE : ACC;
      ACC: begin
        rdd_en    = 1'b1;
        rdw_addr  = wbase_q + BWBANKA'(w_off);
        rdd_addr  = dbase_q + BDBANKA'(d_off);
        shacc_clr = row_entry_q;
        quant_clr = row_entry_q & (r_q == 8'd0);
        if (issue && beat_last) state_d = DRAIN;
      end
      DRAIN: if (drain_end) state_d = QLOAD;
      QLOAD: begin
        quant_load = 1'b1;
        state_d    = QOUT;
      end
      QOUT: begin
        wrd_en     = 1'b1;
        wrd_addr   = obase_q + BDBANKA'(o_off);
        quant_step = wrd_grnt;
        if (wr_fire && k_last) state_d = row_last ? DONE : ACC;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {wbase_q, dbase_q, obase_q, qmsb_q} <= '0;
      {iprec_q, wprec_q, oprec_q, ncol_q, nrow_q} <= '0;
      {r_q, col_q, s_q, wb_q, k_q, dcnt_q} <= '0;
      row_entry_q <= 1'b0;
      beat0_q     <= 1'b0;
      vld_pipe    <= '0;
      flg_pipe    <= '0;
    end else begin
      row_entry_q <= acc_enter;
      vld_pipe[1] <= issue;
      flg_pipe[1] <= {beat0_q, new_s};
      for (int i = 2; i <= RDLAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        flg_pipe[i] <= flg_pipe[i-1];
      end
      if (state_q == IDLE && start) begin
        wbase_q <= cfg_wbase;  dbase_q <= cfg_dbase;  obase_q <= cfg_obase;
        iprec_q <= cfg_iprec;  wprec_q <= cfg_wprec;  oprec_q <= cfg_oprec;
        ncol_q  <= cfg_ncol;   nrow_q  <= cfg_nrow;   qmsb_q  <= cfg_qmsb;
        r_q     <= '0;
      end
      if (wr_fire && k_last && !row_last) r_q <= r_q + 8'd1;
      if (acc_enter) begin
        col_q   <= '0;
        s_q     <= s_init;
        wb_q    <= wb_init;
        beat0_q <= 1'b1;
      end else if (issue) begin
        beat0_q <= 1'b0;
        if (!col_last) col_q <= col_q + 8'd1;
        else begin
          col_q <= '0;
          if (!wb_last) wb_q <= wb_q - 5'd1;
          else if (s_q != 5'd0) begin
            s_q  <= s_m1;
            wb_q <= wb_hi_m1;
          end
        end
      end
      dcnt_q <= (state_q == DRAIN) ? dcnt_q + 8'd1 : 8'd0;
      k_q    <= (state_q == QOUT) ? k_q + 4'(wr_fire) : 4'd0;
    end
  end

`ifdef MVU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((rdd_en & ~rdd_grnt) | (wrd_en & ~wrd_grnt)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvu_ctrl_seq.sv
// tb_mvu_ctrl_seq: randomized bench; a transaction-level model predicts each job's bank reads,
// delayed shacc beats and writebacks, and a per-cycle monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_mvu_ctrl_seq;
  localparam int RDLAT = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [8:0]  cfg_wbase = '0;
  logic [13:0] cfg_dbase = '0, cfg_obase = '0;
  logic [3:0]  cfg_iprec = '0, cfg_wprec = '0, cfg_oprec = '0;
  logic [7:0]  cfg_ncol = '0, cfg_nrow = '0;
  logic [4:0]  cfg_qmsb = '0;
  logic        rdd_grnt = 1'b0, wrd_grnt = 1'b0;
  logic        busy, done, rdd_en, wrd_en;
  logic        shacc_clr, shacc_load, shacc_acc, shacc_sh, quant_clr, quant_load, quant_step;
  logic [8:0]  rdw_addr;
  logic [13:0] rdd_addr, wrd_addr;
  logic [4:0]  quant_msbidx;
`ifdef MVU_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  mvu_ctrl_seq #(.RDLAT(RDLAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase), .cfg_obase(cfg_obase),
    .cfg_iprec(cfg_iprec), .cfg_wprec(cfg_wprec), .cfg_oprec(cfg_oprec),
    .cfg_ncol(cfg_ncol), .cfg_nrow(cfg_nrow), .cfg_qmsb(cfg_qmsb),
    .busy(busy), .done(done), .rdw_addr(rdw_addr), .rdd_en(rdd_en), .rdd_grnt(rdd_grnt),
    .rdd_addr(rdd_addr), .shacc_clr(shacc_clr), .shacc_load(shacc_load), .shacc_acc(shacc_acc),
    .shacc_sh(shacc_sh), .quant_clr(quant_clr), .quant_load(quant_load), .quant_step(quant_step),
    .quant_msbidx(quant_msbidx), .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr)
`ifdef MVU_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = busy | done | (|rdw_addr) | rdd_en | (|rdd_addr) | shacc_clr | shacc_load |
                   shacc_acc | shacc_sh | quant_clr | quant_load | quant_step | (|quant_msbidx) |
                   wrd_en | (|wrd_addr);

  int n_chk = 0, n_pass = 0;
  int c_wbase, c_dbase, c_obase, c_ip, c_wp, c_op, c_ncol, c_nrow, c_qmsb;
  bit c_deg;
  logic [31:0] q_rd[$];
  logic [2:0]  q_fl[$];
  logic [31:0] q_wr[$];
  int          q_pc[$];
  logic [2:0]  q_pf[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_cfg(input int wbase, dbase, obase, ip, wp, op, ncol, nrow, qmsb);
    c_wbase = wbase; c_dbase = dbase; c_obase = obase;
    c_ip = ip; c_wp = wp; c_op = op; c_ncol = ncol; c_nrow = nrow; c_qmsb = qmsb;
    c_deg = (ip == 0) || (wp == 0) || (op == 0) || (ncol == 0) || (nrow == 0);
    cfg_wbase = 9'(wbase); cfg_dbase = 14'(dbase); cfg_obase = 14'(obase);
    cfg_iprec = 4'(ip); cfg_wprec = 4'(wp); cfg_oprec = 4'(op);
    cfg_ncol = 8'(ncol); cfg_nrow = 8'(nrow); cfg_qmsb = 5'(qmsb);
  endtask

  // Expected transaction lists straight from the beat-ordering and address rules
  task automatic build_model();
    int hi, lo, wa, da;
    bit first;
    q_rd.delete(); q_fl.delete(); q_wr.delete(); q_pc.delete(); q_pf.delete();
    if (c_deg) return;
    for (int r = 0; r < c_nrow; r++) begin
      first = 1'b1;
      for (int s = c_wp + c_ip - 2; s >= 0; s--) begin
        hi = (s < c_wp - 1) ? s : c_wp - 1;
        lo = (s - c_ip + 1 > 0) ? s - c_ip + 1 : 0;
        for (int wb = hi; wb >= lo; wb--)
          for (int col = 0; col < c_ncol; col++) begin
            wa = (c_wbase + (r * c_ncol + col) * c_wp + wb) % 512;
            da = (c_dbase + col * c_ip + s - wb) % 16384;
            q_rd.push_back(32'((wa << 14) | da));
            q_fl.push_back({first, !first, (col == 0) && (wb == hi) && !first});
            first = 1'b0;
          end
      end
      for (int k = 0; k < c_op; k++) q_wr.push_back(32'((c_obase + r * c_op + k) % 16384));
    end
  endtask

  task automatic drive_grants(input int rd_p, input int wr_p);
    rdd_grnt = ($urandom_range(99) < rd_p);
    wrd_grnt = ($urandom_range(99) < wr_p);
  endtask

  task automatic run_job(input int rd_p, input int wr_p, input bit busy_pulse);
    int n_sclr = 0, n_qclr = 0, n_qld = 0, n_busy = 0, n_stall = 0, done_cyc = 0;
    bit got_done = 1'b0;
    logic [2:0] exp_sh;
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_grants(rd_p, wr_p);
    for (int c = 1; c <= 3000 && !got_done; c++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 1);
      chk("msbidx", 32'(quant_msbidx), 32'(c_qmsb));
      n_busy++;
      if ((rdd_en && !rdd_grnt) || (wrd_en && !wrd_grnt)) n_stall++;
      if (rdd_en) begin
        if (q_rd.size() == 0) chk("rd_extra", 1, 0);
        else begin
          chk("rdw_addr", 32'(rdw_addr), q_rd[0] >> 14);
          chk("rdd_addr", 32'(rdd_addr), q_rd[0] & 32'h3fff);
          if (rdd_grnt) begin
            void'(q_rd.pop_front());
            q_pc.push_back(c);
            q_pf.push_back(q_fl.pop_front());
          end
        end
      end
      exp_sh = 3'b000;
      if (q_pc.size() > 0 && q_pc[0] + RDLAT == c) begin
        void'(q_pc.pop_front());
        exp_sh = q_pf.pop_front();
      end
      chk("shacc", 32'({shacc_load, shacc_acc, shacc_sh}), 32'(exp_sh));
      if (shacc_clr) n_sclr++;
      if (quant_clr) n_qclr++;
      if (quant_load) begin
        n_qld++;
        chk("qload_drained", 32'(q_pc.size()), 0);
      end
      if (wrd_en) begin
        chk("qstep", 32'(quant_step), 32'(wrd_grnt));
        if (q_wr.size() == 0) chk("wr_extra", 1, 0);
        else begin
          chk("wrd_addr", 32'(wrd_addr), q_wr[0]);
          if (wrd_grnt) void'(q_wr.pop_front());
        end
      end else chk("qstep_idle", 32'(quant_step), 0);
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
      end else begin
        @(posedge clk); #1;
        drive_grants(rd_p, wr_p);
        start = busy_pulse && (c == 2);
        if (start) begin
          cfg_nrow  = 8'd0;
          cfg_dbase = 14'($urandom);
        end
      end
    end
    start = 1'b0;
    if (!got_done) chk("timeout", 0, 1);
    if (c_deg) chk("degen_done_cyc", 32'(done_cyc), 1);
    chk("rd_left", 32'(q_rd.size()), 0);
    chk("wr_left", 32'(q_wr.size()), 0);
    chk("sh_left", 32'(q_pc.size()), 0);
    chk("qload_cnt", 32'(n_qld), c_deg ? 0 : 32'(c_nrow));
    if (!c_deg) begin
      chk("sclr_cnt", 32'(n_sclr), 32'(c_nrow));
      chk("qclr_cnt", 32'(n_qclr), 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after", 32'(busy), 0);
    chk("done_after", 32'(done), 0);
`ifdef MVU_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 32'(n_busy));
    chk("perf_stalls", perf_stalls, 32'(n_stall));
`endif
  endtask

  task automatic abort_job();
    set_cfg(3, 100, 200, 3, 3, 2, 3, 2, 7);
    rdd_grnt = 1'b1; wrd_grnt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", 32'(any_out), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(any_out), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(any_out), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'(any_out), 0);
    @(posedge clk); #1;

    set_cfg(10, 20, 30, 1, 1, 1, 1, 1, 4);        run_job(100, 100, 1'b0);
    set_cfg(0, 40, 300, 2, 2, 1, 1, 1, 9);        run_job(100, 100, 1'b0);
    set_cfg(5, 0, 64, 2, 2, 4, 3, 2, 26);         run_job(100, 100, 1'b0);
    set_cfg(7, 50, 90, 2, 3, 3, 2, 2, 12);        run_job(60, 50, 1'b1);
    abort_job();
    set_cfg(1, 2, 3, 2, 2, 2, 2, 1, 3);           run_job(100, 100, 1'b0);
    set_cfg(4, 5, 6, 2, 2, 2, 2, 0, 5);           run_job(100, 100, 1'b1);
    set_cfg(510, 16383, 16382, 3, 2, 2, 2, 1, 1); run_job(80, 70, 1'b0);
    for (int j = 0; j < 6; j++) begin
      set_cfg($urandom_range(511), $urandom_range(16383), $urandom_range(16383),
              1 + $urandom_range(3), 1 + $urandom_range(3), 1 + $urandom_range(3),
              1 + $urandom_range(2), 1 + $urandom_range(1), $urandom_range(26));
      run_job(40 + $urandom_range(60), 40 + $urandom_range(60), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
